// File: rtl/elastic_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_reg_pkg
// Purpose  : Shared pipeline definitions: occupancy state encoding for the
//            elastic pipeline register and common bubble payload constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package elastic_pipe_reg_pkg;

   // Occupancy of the elastic register: nothing held, main entry held,
   // main plus skid entry held.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_t;

   // Bubble payloads: all-zero, and the RISC-V canonical NOP (addi x0,x0,0)
   // for instruction-carrying boundaries.
   localparam logic [63:0] BUBBLE_ZERO = 64'h0;
   localparam logic [31:0] BUBBLE_NOP  = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at its all-ones value.
// Ports    : clk   - clock
//            clear - synchronous clear (highest priority)
//            inc   - count enable
//            count - current count value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_reg
// Purpose  : Valid/ready pipeline register with optional skid entry, flush,
//            bubble payload on empty, and a saturating stall counter.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            flush                - discard held and incoming entries
//            in_valid/in_ready/in_data    - upstream handshake + payload
//            out_valid/out_ready/out_data - downstream handshake + payload
//            stall_cnt            - cycles with out_valid=1 and out_ready=0
// Revision : 1.0 - initial release
// ============================================================================
module elastic_pipe_reg
   import elastic_pipe_reg_pkg::*;
#(
   parameter int                DATA_W  = 64,
   parameter int                SKID_EN = 1,
   parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(BUBBLE_ZERO),
   parameter int                CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_t       r_state;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;

   // Reset and flush clear the data path identically; they differ only in
   // that flush leaves the stall counter alone. The main register is loaded
   // with BUBBLE whenever the block drains so out_data needs no output mux.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_state <= ST_EMPTY;
         r_main  <= BUBBLE;
         r_skid  <= BUBBLE;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (in_valid) begin
                  r_main  <= in_data;
                  r_state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  if (in_valid) begin
                     r_main <= in_data;
                  end else begin
                     r_main  <= BUBBLE;
                     r_state <= ST_EMPTY;
                  end
               end else if (in_valid && (SKID_EN != 0)) begin
                  r_skid  <= in_data;
                  r_state <= ST_SKID;
               end
            end
            ST_SKID: begin
               // Draining the skid entry takes this cycle; upstream is
               // already stalled by the registered in_ready.
               if (out_ready) begin
                  r_main  <= r_skid;
                  r_skid  <= BUBBLE;
                  r_state <= ST_FULL;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
               r_main  <= BUBBLE;
               r_skid  <= BUBBLE;
            end
         endcase
      end
   end

   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = r_main;

   generate
      if (SKID_EN != 0) begin : g_skid_ready
         logic r_in_ready;
         logic w_next_skid;

         // in_ready is a flop: low exactly when the next state is SKID.
         assign w_next_skid = !out_ready &&
                              (((r_state == ST_FULL) && in_valid) ||
                               (r_state == ST_SKID));

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               r_in_ready <= 1'b1;
            end else begin
               r_in_ready <= !w_next_skid;
            end
         end

         assign in_ready = r_in_ready;
      end else begin : g_comb_ready
         assign in_ready = out_ready || !out_valid;
      end
   endgenerate

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (out_valid && !out_ready),
      .count (stall_cnt)
   );

endmodule
`default_nettype wire
